// File: rtl/led_scan_sequencer.sv
// Select-code generator for the 3-to-8 LED decoder: a debounced step button
// or a prescaled auto tick advances a 3-bit code up or down, with load override.
module led_scan_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TICK_DIV        = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_step,
    input  logic       run_en,
    input  logic       dir,
    input  logic       load,
    input  logic [2:0] load_val,
    output logic [2:0] sel,
    output logic       wrap,
    output logic       step_ack
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {DB_REL, DB_PCHK, DB_PRS, DB_RCHK} db_state_t;
    typedef enum logic {MANUAL, AUTO} mode_t;

    logic            btn_m, btn_s, run_m, run_s;
    db_state_t       db_state, db_next;
    logic [DB_W-1:0] db_cnt, db_cnt_next;
    logic            press, press_next;
    mode_t           mode, mode_next;
    logic [PS_W-1:0] presc;
    logic            tick, adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
            run_m <= 1'b0;
            run_s <= 1'b0;
        end else begin
            btn_m <= btn_step;
            btn_s <= btn_m;
            run_m <= run_en;
            run_s <= run_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_state <= DB_REL;
            db_cnt   <= '0;
            press    <= 1'b0;
            mode     <= MANUAL;
        end else begin
            db_state <= db_next;
            db_cnt   <= db_cnt_next;
            press    <= press_next;
            mode     <= mode_next;
        end
    end

    // Press is only declared after btn_s stays high for DEBOUNCE_CYCLES
    // consecutive cycles; release needs the same stability before re-arming.
    always_comb begin
        db_next     = db_state;
        db_cnt_next = db_cnt;
        press_next  = 1'b0;
        case (db_state)
            DB_REL: begin
                if (btn_s) begin
                    db_next     = DB_PCHK;
                    db_cnt_next = '0;
                end
            end
            DB_PCHK: begin
                if (!btn_s) begin
                    db_next = DB_REL;
                end else begin
                    db_cnt_next = db_cnt + 1'b1;
                    if (db_cnt == DB_LAST) begin
                        db_next    = DB_PRS;
                        press_next = 1'b1;
                    end
                end
            end
            DB_PRS: begin
                if (!btn_s) begin
                    db_next     = DB_RCHK;
                    db_cnt_next = '0;
                end
            end
            DB_RCHK: begin
                if (btn_s) begin
                    db_next = DB_PRS;
                end else begin
                    db_cnt_next = db_cnt + 1'b1;
                    if (db_cnt == DB_LAST) begin
                        db_next = DB_REL;
                    end
                end
            end
            default: db_next = DB_REL;
        endcase
    end

    always_comb begin
        mode_next = run_s ? AUTO : MANUAL;
    end

    // Held at zero in MANUAL, so entering AUTO always starts a full period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (mode != AUTO) begin
            presc <= '0;
        end else if (presc == PS_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign tick     = (mode == AUTO) && (presc == PS_LAST);
    assign adv      = press | tick;
    assign step_ack = press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel  <= 3'd0;
            wrap <= 1'b0;
        end else if (load) begin
            sel  <= load_val;
            wrap <= 1'b0;
        end else if (adv) begin
            if (dir) begin
                sel  <= sel - 3'd1;
                wrap <= (sel == 3'd0);
            end else begin
                sel  <= sel + 3'd1;
                wrap <= (sel == 3'd7);
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_led_scan_sequencer.sv
// Directed bench for led_scan_sequencer with DEBOUNCE_CYCLES=4, TICK_DIV=5.
module tb_led_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_step = 1'b0;
    logic       run_en = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [2:0] load_val = 3'd0;
    logic [2:0] sel;
    logic       wrap;
    logic       step_ack;

    int check_count = 0;
    int pass_count  = 0;
    int ack_count;
    int exp_sel;
    int exp_wrap;

    led_scan_sequencer #(.DEBOUNCE_CYCLES(4), .TICK_DIV(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_step (btn_step),
        .run_en   (run_en),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .sel      (sel),
        .wrap     (wrap),
        .step_ack (step_ack)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        check_count++;
        if (observed == expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic b, input logic r, input logic d,
                                 input logic l, input logic [2:0] lv);
        btn_step = b;
        run_en   = r;
        dir      = d;
        load     = l;
        load_val = lv;
    endtask

    // Leaves the bench 1 time unit after the first edge out of reset.
    task automatic applyReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        applyReset();
        checkOutput("reset_sel", sel, 0);
        checkOutput("reset_wrap", wrap, 0);
        checkOutput("reset_ack", step_ack, 0);

        $display("[TB] debounced step");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        for (int k = 1; k <= 20; k++) begin
            stepCycle();
            checkOutput($sformatf("t1_ack_%0d", k), step_ack, (k == 7) ? 1 : 0);
            checkOutput($sformatf("t1_sel_%0d", k), sel, (k >= 8) ? 1 : 0);
        end
        btn_step = 1'b0;
        repeat (10) stepCycle();
        btn_step = 1'b1;
        ack_count = 0;
        for (int k = 1; k <= 20; k++) begin
            stepCycle();
            if (step_ack) ack_count++;
        end
        btn_step = 1'b0;
        checkOutput("t1_second_ack_count", ack_count, 1);
        checkOutput("t1_second_sel", sel, 2);

        $display("[TB] glitch rejection");
        applyReset();
        ack_count = 0;
        for (int p = 0; p < 5; p++) begin
            btn_step = 1'b1;
            repeat (3) begin
                stepCycle();
                if (step_ack) ack_count++;
            end
            btn_step = 1'b0;
            repeat (2) begin
                stepCycle();
                if (step_ack) ack_count++;
            end
        end
        repeat (10) begin
            stepCycle();
            if (step_ack) ack_count++;
        end
        checkOutput("t2_ack_count", ack_count, 0);
        checkOutput("t2_sel", sel, 0);

        $display("[TB] auto up with wrap, then down count and load priority");
        applyReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd6);
        stepCycle();
        checkOutput("t3_load6", sel, 6);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        for (int k = 1; k <= 44; k++) begin
            stepCycle();
            if (k < 8)       exp_sel = 6;
            else if (k < 13) exp_sel = 7;
            else if (k < 18) exp_sel = 0;
            else if (k < 23) exp_sel = 1;
            else if (k < 28) exp_sel = 3;
            else if (k < 33) exp_sel = 2;
            else if (k < 38) exp_sel = 1;
            else if (k < 43) exp_sel = 0;
            else             exp_sel = 7;
            exp_wrap = (k == 13 || k == 43) ? 1 : 0;
            checkOutput($sformatf("t34_sel_%0d", k), sel, exp_sel);
            checkOutput($sformatf("t34_wrap_%0d", k), wrap, exp_wrap);
            if (k == 18) dir = 1'b1;
            if (k == 22) begin
                load     = 1'b1;
                load_val = 3'd3;
            end
            if (k == 23) load = 1'b0;
        end

        $display("[TB] simultaneous press and tick");
        applyReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        for (int k = 1; k <= 14; k++) begin
            stepCycle();
            if (k < 8)       exp_sel = 0;
            else if (k < 13) exp_sel = 1;
            else             exp_sel = 2;
            checkOutput($sformatf("t5_ack_%0d", k), step_ack, (k == 7) ? 1 : 0);
            checkOutput($sformatf("t5_sel_%0d", k), sel, exp_sel);
        end

        $display("[TB] reset mid-debounce");
        applyReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd5);
        stepCycle();
        checkOutput("t6_load5", sel, 5);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        repeat (4) stepCycle();
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_sel", sel, 0);
        checkOutput("t6_async_wrap", wrap, 0);
        checkOutput("t6_async_ack", step_ack, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            stepCycle();
            checkOutput($sformatf("t6_ack_%0d", k), step_ack, (k == 7) ? 1 : 0);
            checkOutput($sformatf("t6_sel_%0d", k), sel, (k >= 8) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
